crypto_ratio_trigger: RTL and testbench
=======================================

CRYPTO_RATIO_TRIGGER -- requirements
Module: crypto_ratio_trigger

Interface
REQ-001 Parameter PRICE_W, default 64, price width in bits.
REQ-002 Parameter SHIFT, default 4, ratio exponent: reference value is eth_price*2^SHIFT.
REQ-003 Parameter COOLDOWN_CYC, default 8, cycles spent in COOLDOWN after a trade is accepted; 0 is legal.
REQ-004 Parameter CNT_W, default 16, width of miss_cnt.
REQ-005 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port px_valid, input, 1, price pair valid this cycle.
REQ-008 Port btc_price, input, PRICE_W, BTC price.
REQ-009 Port eth_price, input, PRICE_W, ETH price.
REQ-010 Port cfg_dir, input, 1, 0 = fire when BTC rich, 1 = fire when BTC cheap.
REQ-011 Port cfg_thresh, input, PRICE_W, trigger margin.
REQ-012 Port cfg_hyst, input, PRICE_W, re-arm hysteresis margin.
REQ-013 Port trade_valid, output, 1, trade offer pending.
REQ-014 Port trade_ready, input, 1, downstream accepts the trade.
REQ-015 Port trade_price, output, PRICE_W, ETH price of the firing sample.
REQ-016 Port trade_btc, output, PRICE_W, BTC price of the firing sample.
REQ-017 Port trade_dir, output, 1, cfg_dir value captured at fire.
REQ-018 Port armed, output, 1, high only in state ARMED.
REQ-019 Port miss_cnt, output, CNT_W, count of firing-qualified samples dropped while not ARMED.

Function
REQ-020 Stage 1 shall register px_valid, both prices and cfg_dir on every cycle; cfg_thresh and cfg_hyst are used unregistered in stage 2.
REQ-021 All comparisons shall use W = PRICE_W+SHIFT+2 unsigned bits, with no truncation: R = eth<<SHIFT, B = btc.
REQ-022 Fire condition: dir=0 -> B > R+thresh; dir=1 -> B+thresh < R.
REQ-023 Clear condition: dir=0 -> B+hyst <= R+thresh; dir=1 -> B+thresh >= R+hyst.
REQ-024 States are ARMED, FIRE, COOLDOWN and WAIT_CLEAR; the reset state is ARMED.
REQ-025 In ARMED, a stage-1 valid sample meeting the fire condition shall cause a move to FIRE and capture trade_price, trade_btc and trade_dir.
REQ-026 Latency: trade_valid shall rise exactly 2 cycles after the px_valid cycle that fired.
REQ-027 In FIRE, trade_valid=1 and the trade outputs shall hold stable until trade_valid and trade_ready are both high on the same edge.
REQ-028 On acceptance, the block shall go to COOLDOWN with counter = COOLDOWN_CYC-1, or directly to WAIT_CLEAR if COOLDOWN_CYC=0.
REQ-029 In COOLDOWN, the counter shall decrement every cycle, and the block shall go to WAIT_CLEAR in the cycle after the counter reads 0.
REQ-030 In WAIT_CLEAR, a stage-1 valid sample meeting the clear condition shall cause a move to ARMED; no sample shall both clear and fire in the same cycle.
REQ-031 miss_cnt shall increment, saturating at all-ones, for each stage-1 valid sample meeting the fire condition while the state is not ARMED.
REQ-032 trade_ready while trade_valid=0 shall be ignored.
REQ-033 A cfg_dir change shall take effect only on samples registered after the change.

Reset
REQ-034 When rst is high at a clock edge, the block shall enter ARMED and set every output register and the pipeline valid bit to 0, with armed=1.
REQ-035 A reset asserted mid-FIRE shall drop trade_valid the next cycle with no handshake, and the pending trade shall be discarded.

Structure
REQ-036 The state enum and default parameter constants shall live in package crypto_hft_pkg.
REQ-037 Sub-module crypto_ratio_cmp shall be used: combinational, producing fire and clear from B, R, thresh, hyst and dir.
REQ-038 The sub-module, pipeline and FSM together shall total 120-400 RTL lines.

Verification (SHIFT=4, COOLDOWN_CYC=3, thresh=0, hyst=0 unless stated)
REQ-039 Scenario: dir=0, eth=100, btc=1601, ready=1 -> trade_valid rises 2 cycles later, trade_price=100, trade_btc=1601; btc=1600 -> no fire.
REQ-040 Scenario: dir=1, thresh=10, eth=100, btc=1589 -> fire; btc=1590 -> no fire.
REQ-041 Scenario: ready=0 for 5 cycles while firing samples arrive every cycle -> outputs stay stable and miss_cnt=5; raising ready -> 3 COOLDOWN cycles, then WAIT_CLEAR.
REQ-042 Scenario: hyst=50, dir=0, eth=100 -> after a trade, btc=1560 keeps WAIT_CLEAR, btc=1550 returns to ARMED, and a following btc=1601 fires again.
REQ-043 Scenario: eth=2^64-1, btc=2^64-1, dir=0 -> no fire, and no overflow wrap yields a false trigger.
REQ-044 Scenario: rst pulsed during FIRE -> trade_valid=0, armed=1 and miss_cnt=0 on the next cycle.

Source files
------------

// File: rtl/crypto_hft_pkg.sv
// Purpose: shared types and default constants for the crypto ratio trigger.
// Contents: trigger FSM state enum plus default parameter values.
package crypto_hft_pkg;

    localparam int unsigned DEF_PRICE_W      = 64;
    localparam int unsigned DEF_SHIFT        = 4;
    localparam int unsigned DEF_COOLDOWN_CYC = 8;
    localparam int unsigned DEF_CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_ARMED      = 2'd0,
        ST_FIRE       = 2'd1,
        ST_COOLDOWN   = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } state_e;

endpackage : crypto_hft_pkg

// File: rtl/crypto_ratio_cmp.sv
// Purpose: combinational BTC/ETH ratio comparator producing fire and clear.
// Ports:
//   btc_i, eth_i       : registered sample prices
//   thresh_i, hyst_i   : trigger margin and re-arm hysteresis
//   dir_i              : 0 = fire when BTC rich, 1 = fire when BTC cheap
//   fire_o, clear_o    : combinational fire / clear qualifiers
module crypto_ratio_cmp #(
    parameter int unsigned PRICE_W = 64,
    parameter int unsigned SHIFT   = 4
) (
    input  logic [PRICE_W-1:0] btc_i,
    input  logic [PRICE_W-1:0] eth_i,
    input  logic [PRICE_W-1:0] thresh_i,
    input  logic [PRICE_W-1:0] hyst_i,
    input  logic               dir_i,
    output logic               fire_o,
    output logic               clear_o
);

    // Two guard bits keep every sum of two operands exact.
    localparam int unsigned W = PRICE_W + SHIFT + 2;

    logic [W-1:0] b_w;
    logic [W-1:0] r_w;
    logic [W-1:0] t_w;
    logic [W-1:0] h_w;

    assign b_w = W'(btc_i);
    assign r_w = W'(eth_i) << SHIFT;
    assign t_w = W'(thresh_i);
    assign h_w = W'(hyst_i);

    // Fire / clear qualifiers for both trade directions.
    always_comb begin
        fire_o  = 1'b0;
        clear_o = 1'b0;
        if (!dir_i) begin
            fire_o  = b_w > (r_w + t_w);
            clear_o = (b_w + h_w) <= (r_w + t_w);
        end else begin
            fire_o  = (b_w + t_w) < r_w;
            clear_o = (b_w + t_w) >= (r_w + h_w);
        end
    end

endmodule : crypto_ratio_cmp

// File: rtl/crypto_ratio_trigger.sv
// Purpose: ratio-based trade trigger with a one-stage input pipeline, a
//          valid/ready trade offer, cooldown and hysteresis re-arming.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   px_valid, btc_price,
//   eth_price, cfg_dir          : price sample and direction (registered)
//   cfg_thresh, cfg_hyst        : margins used directly by the comparator
//   trade_valid/ready           : trade offer handshake
//   trade_price, trade_btc,
//   trade_dir                   : payload captured from the firing sample
//   armed                       : high only in ARMED
//   miss_cnt                    : saturating count of firing samples dropped
module crypto_ratio_trigger
    import crypto_hft_pkg::*;
#(
    parameter int unsigned PRICE_W      = DEF_PRICE_W,
    parameter int unsigned SHIFT        = DEF_SHIFT,
    parameter int unsigned COOLDOWN_CYC = DEF_COOLDOWN_CYC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               px_valid,
    input  logic [PRICE_W-1:0] btc_price,
    input  logic [PRICE_W-1:0] eth_price,
    input  logic               cfg_dir,
    input  logic [PRICE_W-1:0] cfg_thresh,
    input  logic [PRICE_W-1:0] cfg_hyst,
    output logic               trade_valid,
    input  logic               trade_ready,
    output logic [PRICE_W-1:0] trade_price,
    output logic [PRICE_W-1:0] trade_btc,
    output logic               trade_dir,
    output logic               armed,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int unsigned CD_W = (COOLDOWN_CYC > 2) ? $clog2(COOLDOWN_CYC) : 1;

    // Stage-1 sample registers
    logic               s1_valid_q;
    logic [PRICE_W-1:0] s1_btc_q;
    logic [PRICE_W-1:0] s1_eth_q;
    logic               s1_dir_q;

    // FSM and output registers
    state_e             state_q,       state_d;
    logic [CD_W-1:0]    cd_cnt_q,      cd_cnt_d;
    logic               trade_valid_q, trade_valid_d;
    logic [PRICE_W-1:0] trade_price_q, trade_price_d;
    logic [PRICE_W-1:0] trade_btc_q,   trade_btc_d;
    logic               trade_dir_q,   trade_dir_d;
    logic               armed_q,       armed_d;
    logic [CNT_W-1:0]   miss_cnt_q,    miss_cnt_d;

    logic               fire_c;
    logic               clear_c;

    // Stage 1: capture the sample every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_btc_q   <= '0;
            s1_eth_q   <= '0;
            s1_dir_q   <= 1'b0;
        end else begin
            s1_valid_q <= px_valid;
            s1_btc_q   <= btc_price;
            s1_eth_q   <= eth_price;
            s1_dir_q   <= cfg_dir;
        end
    end

    crypto_ratio_cmp #(
        .PRICE_W (PRICE_W),
        .SHIFT   (SHIFT)
    ) u_cmp (
        .btc_i    (s1_btc_q),
        .eth_i    (s1_eth_q),
        .thresh_i (cfg_thresh),
        .hyst_i   (cfg_hyst),
        .dir_i    (s1_dir_q),
        .fire_o   (fire_c),
        .clear_o  (clear_c)
    );

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ARMED;
            cd_cnt_q      <= '0;
            trade_valid_q <= 1'b0;
            trade_price_q <= '0;
            trade_btc_q   <= '0;
            trade_dir_q   <= 1'b0;
            armed_q       <= 1'b1;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cd_cnt_q      <= cd_cnt_d;
            trade_valid_q <= trade_valid_d;
            trade_price_q <= trade_price_d;
            trade_btc_q   <= trade_btc_d;
            trade_dir_q   <= trade_dir_d;
            armed_q       <= armed_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cd_cnt_d      = cd_cnt_q;
        trade_valid_d = trade_valid_q;
        trade_price_d = trade_price_q;
        trade_btc_d   = trade_btc_q;
        trade_dir_d   = trade_dir_q;
        miss_cnt_d    = miss_cnt_q;

        unique case (state_q)
            ST_ARMED: begin
                if (s1_valid_q && fire_c) begin
                    state_d       = ST_FIRE;
                    trade_valid_d = 1'b1;
                    trade_price_d = s1_eth_q;
                    trade_btc_d   = s1_btc_q;
                    trade_dir_d   = s1_dir_q;
                end
            end
            ST_FIRE: begin
                if (trade_valid_q && trade_ready) begin
                    trade_valid_d = 1'b0;
                    if (COOLDOWN_CYC == 0) begin
                        state_d = ST_WAIT_CLEAR;
                    end else begin
                        state_d  = ST_COOLDOWN;
                        cd_cnt_d = CD_W'(COOLDOWN_CYC - 1);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt_q == '0) begin
                    state_d = ST_WAIT_CLEAR;
                end else begin
                    cd_cnt_d = cd_cnt_q - CD_W'(1);
                end
            end
            ST_WAIT_CLEAR: begin
                if (s1_valid_q && clear_c) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d       = ST_ARMED;
                trade_valid_d = 1'b0;
            end
        endcase

        // Firing samples that arrive while not ARMED are dropped and counted.
        if (s1_valid_q && fire_c && (state_q != ST_ARMED) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end

        armed_d = (state_d == ST_ARMED);
    end

    assign trade_valid = trade_valid_q;
    assign trade_price = trade_price_q;
    assign trade_btc   = trade_btc_q;
    assign trade_dir   = trade_dir_q;
    assign armed       = armed_q;
    assign miss_cnt    = miss_cnt_q;

endmodule : crypto_ratio_trigger

// File: tb/tb_crypto_ratio_trigger.sv
// Purpose: directed self-checking bench for crypto_ratio_trigger
//          (SHIFT=4, COOLDOWN_CYC=3, PRICE_W=64, CNT_W=16).
module tb_crypto_ratio_trigger;

    localparam int unsigned PW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          px_valid;
    logic [PW-1:0] btc_price;
    logic [PW-1:0] eth_price;
    logic          cfg_dir;
    logic [PW-1:0] cfg_thresh;
    logic [PW-1:0] cfg_hyst;
    logic          trade_valid;
    logic          trade_ready;
    logic [PW-1:0] trade_price;
    logic [PW-1:0] trade_btc;
    logic          trade_dir;
    logic          armed;
    logic [15:0]   miss_cnt;

    int checks   = 0;
    int failures = 0;

    crypto_ratio_trigger #(
        .PRICE_W      (64),
        .SHIFT        (4),
        .COOLDOWN_CYC (3),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .px_valid    (px_valid),
        .btc_price   (btc_price),
        .eth_price   (eth_price),
        .cfg_dir     (cfg_dir),
        .cfg_thresh  (cfg_thresh),
        .cfg_hyst    (cfg_hyst),
        .trade_valid (trade_valid),
        .trade_ready (trade_ready),
        .trade_price (trade_price),
        .trade_btc   (trade_btc),
        .trade_dir   (trade_dir),
        .armed       (armed),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic v, input logic [PW-1:0] btc, input logic [PW-1:0] eth);
        px_valid  = v;
        btc_price = btc;
        eth_price = eth;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        px(1'b0, '0, '0);
        cfg_dir = 1'b0; cfg_thresh = '0; cfg_hyst = '0; trade_ready = 1'b0;
        do_reset();
        checks++;
        if (trade_valid !== 1'b0) begin failures++; $display("FAIL rst_tv got=%0d exp=0", trade_valid); end
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL rst_armed got=%0d exp=1", armed); end
        checks++;
        if (miss_cnt !== 16'd0) begin failures++; $display("FAIL rst_miss got=%0d exp=0", miss_cnt); end
        checks++;
        if (trade_price !== 64'd0 || trade_btc !== 64'd0) begin
            failures++; $display("FAIL rst_payload got=%0d/%0d exp=0/0", trade_price, trade_btc);
        end
        // ready without a pending offer changes nothing
        trade_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (armed !== 1'b1 || trade_valid !== 1'b0) begin
            failures++; $display("FAIL ready_ignored armed=%0d tv=%0d exp=1/0", armed, trade_valid);
        end
    endtask

    task automatic test_fire_dir0();
        cfg_dir = 1'b0; cfg_thresh = '0; cfg_hyst = '0; trade_ready = 1'b1;
        px(1'b1, 64'd1601, 64'd100);
        tick();
        checks++;
        if (trade_valid !== 1'b0) begin failures++; $display("FAIL d0_early_tv got=%0d exp=0", trade_valid); end
        // direction flips after the sample was registered: must not affect this trade
        px(1'b0, '0, '0);
        cfg_dir = 1'b1;
        tick();
        checks++;
        if (trade_valid !== 1'b1) begin failures++; $display("FAIL d0_tv got=%0d exp=1", trade_valid); end
        checks++;
        if (trade_price !== 64'd100 || trade_btc !== 64'd1601) begin
            failures++; $display("FAIL d0_payload got=%0d/%0d exp=100/1601", trade_price, trade_btc);
        end
        checks++;
        if (trade_dir !== 1'b0) begin failures++; $display("FAIL d0_dir got=%0d exp=0", trade_dir); end
        checks++;
        if (armed !== 1'b0) begin failures++; $display("FAIL d0_armed got=%0d exp=0", armed); end
        tick();
        checks++;
        if (trade_valid !== 1'b0) begin failures++; $display("FAIL d0_accept_tv got=%0d exp=0", trade_valid); end
        repeat (4) tick();
        cfg_dir = 1'b0;
        px(1'b1, 64'd1600, 64'd100);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL d0_rearm got=%0d exp=1", armed); end
        px(1'b1, 64'd1600, 64'd100);
        tick();
        px(1'b0, '0, '0);
        repeat (2) tick();
        checks++;
        if (trade_valid !== 1'b0 || armed !== 1'b1) begin
            failures++; $display("FAIL d0_nofire tv=%0d armed=%0d exp=0/1", trade_valid, armed);
        end
    endtask

    task automatic test_fire_dir1();
        cfg_dir = 1'b1; cfg_thresh = 64'd10; trade_ready = 1'b0;
        px(1'b1, 64'd1589, 64'd100);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (trade_valid !== 1'b1 || trade_btc !== 64'd1589 || trade_dir !== 1'b1) begin
            failures++; $display("FAIL d1_fire tv=%0d btc=%0d dir=%0d exp=1/1589/1", trade_valid, trade_btc, trade_dir);
        end
        tick();
        checks++;
        if (trade_valid !== 1'b1) begin failures++; $display("FAIL d1_hold got=%0d exp=1", trade_valid); end
        trade_ready = 1'b1;
        tick();
        checks++;
        if (trade_valid !== 1'b0) begin failures++; $display("FAIL d1_accept got=%0d exp=0", trade_valid); end
        repeat (4) tick();
        px(1'b1, 64'd1590, 64'd100);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL d1_rearm got=%0d exp=1", armed); end
        px(1'b1, 64'd1590, 64'd100);
        tick();
        px(1'b0, '0, '0);
        repeat (2) tick();
        checks++;
        if (trade_valid !== 1'b0 || armed !== 1'b1) begin
            failures++; $display("FAIL d1_nofire tv=%0d armed=%0d exp=0/1", trade_valid, armed);
        end
        cfg_thresh = '0;
        cfg_dir = 1'b0;
    endtask

    task automatic test_backpressure();
        trade_ready = 1'b0;
        do_reset();
        px(1'b1, 64'd1601, 64'd100);
        tick();
        btc_price = 64'd1700;
        repeat (5) tick();
        px_valid = 1'b0;
        tick();
        checks++;
        if (trade_valid !== 1'b1 || trade_btc !== 64'd1601 || trade_price !== 64'd100) begin
            failures++; $display("FAIL bp_stable tv=%0d btc=%0d px=%0d exp=1/1601/100", trade_valid, trade_btc, trade_price);
        end
        checks++;
        if (miss_cnt !== 16'd5) begin failures++; $display("FAIL bp_miss got=%0d exp=5", miss_cnt); end
        // accept, then feed clearing samples continuously: re-arm exactly after 3 cooldown cycles
        trade_ready = 1'b1;
        px(1'b1, 64'd1600, 64'd100);
        tick();
        checks++;
        if (trade_valid !== 1'b0 || armed !== 1'b0) begin
            failures++; $display("FAIL bp_accept tv=%0d armed=%0d exp=0/0", trade_valid, armed);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (armed !== 1'b0) begin failures++; $display("FAIL bp_cooldown%0d armed=%0d exp=0", i, armed); end
        end
        tick();
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL bp_rearm got=%0d exp=1", armed); end
        checks++;
        if (miss_cnt !== 16'd5) begin failures++; $display("FAIL bp_miss_hold got=%0d exp=5", miss_cnt); end
        px(1'b0, '0, '0);
        trade_ready = 1'b0;
    endtask

    task automatic test_hysteresis();
        do_reset();
        cfg_dir = 1'b0; cfg_thresh = '0; cfg_hyst = 64'd50; trade_ready = 1'b1;
        px(1'b1, 64'd1601, 64'd100);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (trade_valid !== 1'b1) begin failures++; $display("FAIL hy_fire1 got=%0d exp=1", trade_valid); end
        repeat (5) tick();
        px(1'b1, 64'd1560, 64'd100);
        tick();
        px(1'b0, '0, '0);
        repeat (2) tick();
        checks++;
        if (armed !== 1'b0) begin failures++; $display("FAIL hy_hold got=%0d exp=0", armed); end
        px(1'b1, 64'd1550, 64'd100);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL hy_rearm got=%0d exp=1", armed); end
        px(1'b1, 64'd1601, 64'd100);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (trade_valid !== 1'b1 || trade_btc !== 64'd1601) begin
            failures++; $display("FAIL hy_fire2 tv=%0d btc=%0d exp=1/1601", trade_valid, trade_btc);
        end
        tick();
        cfg_hyst = '0;
    endtask

    task automatic test_overflow();
        do_reset();
        cfg_dir = 1'b0; cfg_thresh = '0; trade_ready = 1'b0;
        px(1'b1, '1, '1);
        tick();
        px(1'b0, '0, '0);
        repeat (2) tick();
        checks++;
        if (trade_valid !== 1'b0 || armed !== 1'b1) begin
            failures++; $display("FAIL ovf_nofire tv=%0d armed=%0d exp=0/1", trade_valid, armed);
        end
        // btc=0 plus max margin still far below 16x max eth: cheap-side fire
        cfg_dir = 1'b1; cfg_thresh = '1;
        px(1'b1, '0, '1);
        tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (trade_valid !== 1'b1 || trade_price !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++; $display("FAIL ovf_fire tv=%0d px=%0h exp=1/ffffffffffffffff", trade_valid, trade_price);
        end
        cfg_dir = 1'b0; cfg_thresh = '0;
    endtask

    task automatic test_reset_mid_fire();
        do_reset();
        cfg_dir = 1'b0; cfg_thresh = '0; cfg_hyst = '0; trade_ready = 1'b0;
        px(1'b1, 64'd1601, 64'd100);
        repeat (2) tick();
        px(1'b0, '0, '0);
        tick();
        checks++;
        if (trade_valid !== 1'b1 || miss_cnt !== 16'd1) begin
            failures++; $display("FAIL rf_pre tv=%0d miss=%0d exp=1/1", trade_valid, miss_cnt);
        end
        do_reset();
        checks++;
        if (trade_valid !== 1'b0 || armed !== 1'b1 || miss_cnt !== 16'd0) begin
            failures++; $display("FAIL rf_post tv=%0d armed=%0d miss=%0d exp=0/1/0", trade_valid, armed, miss_cnt);
        end
        trade_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (trade_valid !== 1'b0 || armed !== 1'b1) begin
            failures++; $display("FAIL rf_discard tv=%0d armed=%0d exp=0/1", trade_valid, armed);
        end
    endtask

    initial begin
        rst = 1'b1;
        px(1'b0, '0, '0);
        cfg_dir = 1'b0; cfg_thresh = '0; cfg_hyst = '0; trade_ready = 1'b0;
        test_reset();
        test_fire_dir0();
        test_fire_dir1();
        test_backpressure();
        test_hysteresis();
        test_overflow();
        test_reset_mid_fire();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_crypto_ratio_trigger
